// File: rtl/rf_1p_arb_if.sv
// Bundle of requester A/B handshakes and single-port RF pins for rf_1p_arb.
// master = requesters plus RF model side, slave = the arbiter.
interface rf_1p_arb_if #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
);
  logic                  a_req_i;
  logic                  a_wen_i;
  logic [Addr_Width-1:0] a_addr_i;
  logic [Word_Width-1:0] a_data_i;
  logic                  a_ack_o;
  logic                  a_rvalid_o;
  logic [Word_Width-1:0] a_rdata_o;

  logic                  b_req_i;
  logic                  b_wen_i;
  logic [Addr_Width-1:0] b_addr_i;
  logic [Word_Width-1:0] b_data_i;
  logic                  b_ack_o;
  logic                  b_rvalid_o;
  logic [Word_Width-1:0] b_rdata_o;

  logic                  rf_cen_o;
  logic                  rf_wen_o;
  logic [Addr_Width-1:0] rf_addr_o;
  logic [Word_Width-1:0] rf_data_o;
  logic [Word_Width-1:0] rf_data_i;

  modport slave (
    input  a_req_i, a_wen_i, a_addr_i, a_data_i,
    output a_ack_o, a_rvalid_o, a_rdata_o,
    input  b_req_i, b_wen_i, b_addr_i, b_data_i,
    output b_ack_o, b_rvalid_o, b_rdata_o,
    output rf_cen_o, rf_wen_o, rf_addr_o, rf_data_o,
    input  rf_data_i
  );

  modport master (
    output a_req_i, a_wen_i, a_addr_i, a_data_i,
    input  a_ack_o, a_rvalid_o, a_rdata_o,
    output b_req_i, b_wen_i, b_addr_i, b_data_i,
    input  b_ack_o, b_rvalid_o, b_rdata_o,
    input  rf_cen_o, rf_wen_o, rf_addr_o, rf_data_o,
    output rf_data_i
  );
endinterface

// File: rtl/rf_1p_arb.sv
// Two-requester arbiter/sequencer for a single-port RF with one-cycle registered read.
// Macro RF_ARB_RR_EN selects round-robin tie-break; undefined gives A fixed priority.
module rf_1p_arb #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rf_1p_arb_if.slave bus
);

`ifdef RF_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic                  r_last_b;
  logic                  r_cen;
  logic                  r_wen;
  logic [Addr_Width-1:0] r_addr;
  logic [Word_Width-1:0] r_data;
  logic                  r_s1_vld;
  logic                  r_s1_own;
  logic                  r_s2_vld;
  logic                  r_s2_own;

  logic                  w_tie_b;
  logic                  w_gnt_a;
  logic                  w_gnt_b;
  logic                  w_gnt;
  logic                  w_sel_wen;
  logic [Addr_Width-1:0] w_sel_addr;
  logic [Word_Width-1:0] w_sel_data;

  // Tie goes to B only in round-robin mode and only if A was served last.
  assign w_tie_b = RrEn & ~r_last_b;

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (rst_n) begin
      if (bus.a_req_i && bus.b_req_i) begin
        w_gnt_b = w_tie_b;
        w_gnt_a = ~w_tie_b;
      end else begin
        w_gnt_a = bus.a_req_i;
        w_gnt_b = bus.b_req_i;
      end
    end
  end

  assign w_gnt      = w_gnt_a | w_gnt_b;
  assign w_sel_wen  = w_gnt_b ? bus.b_wen_i  : bus.a_wen_i;
  assign w_sel_addr = w_gnt_b ? bus.b_addr_i : bus.a_addr_i;
  assign w_sel_data = w_gnt_b ? bus.b_data_i : bus.a_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
      r_cen    <= 1'b1;
      r_wen    <= 1'b1;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_cen <= ~w_gnt;
      r_wen <= w_gnt ? w_sel_wen : 1'b1;
      if (w_gnt) begin
        r_addr   <= w_sel_addr;
        r_data   <= w_sel_data;
        r_last_b <= w_gnt_b;
      end
    end
  end

  // Read-return pipe: stage 1 mirrors the RF command cycle, stage 2 the data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_own <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_own <= 1'b0;
    end else begin
      r_s1_vld <= w_gnt & w_sel_wen;
      r_s1_own <= w_gnt_b;
      r_s2_vld <= r_s1_vld;
      r_s2_own <= r_s1_own;
    end
  end

  assign bus.a_ack_o    = w_gnt_a;
  assign bus.b_ack_o    = w_gnt_b;
  assign bus.a_rvalid_o = r_s2_vld & ~r_s2_own;
  assign bus.b_rvalid_o = r_s2_vld &  r_s2_own;
  assign bus.a_rdata_o  = bus.rf_data_i;
  assign bus.b_rdata_o  = bus.rf_data_i;

  assign bus.rf_cen_o  = r_cen;
  assign bus.rf_wen_o  = r_wen;
  assign bus.rf_addr_o = r_addr;
  assign bus.rf_data_o = r_data;

endmodule

// File: tb/tb_rf_1p_arb.sv
// Self-checking bench for rf_1p_arb: RF memory model plus a transaction-level
// reference (grant rule, memory contents, queue of pending read returns).
module tb_rf_1p_arb;
  localparam int WW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_1p_arb_if #(.Word_Width(WW), .Addr_Width(AW)) bus ();
  rf_1p_arb #(.Word_Width(WW), .Addr_Width(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Single-port RF with registered read.
  logic [WW-1:0] ram [256];
  always @(posedge clk) begin
    if (!bus.rf_cen_o) begin
      if (!bus.rf_wen_o) ram[bus.rf_addr_o] <= bus.rf_data_o;
      else               bus.rf_data_i <= ram[bus.rf_addr_o];
    end
  end

  typedef struct {
    int          due;
    bit          own;
    logic [WW-1:0] d;
  } rd_t;

  logic [WW-1:0] m_mem [256];
  rd_t           pend[$];
  bit            m_last_b;
  logic          m_cen, m_wen;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_data;
  bit            g_a, g_b;
  int            cyc;
  int            n_cmp, n_err;

  function automatic logic [WW-1:0] init_val(int i);
    return 32'hA5C30000 ^ (i * 32'h00010101);
  endfunction

  task automatic model_reset();
    m_last_b = 1'b1;
    m_cen = 1'b1; m_wen = 1'b1; m_addr = '0; m_data = '0;
    pend.delete();
  endtask

  task automatic clear_reqs();
    bus.a_req_i = 0; bus.a_wen_i = 1; bus.a_addr_i = '0; bus.a_data_i = '0;
    bus.b_req_i = 0; bus.b_wen_i = 1; bus.b_addr_i = '0; bus.b_data_i = '0;
  endtask

  task automatic check_pins(string tag);
    n_cmp++;
    if ({bus.rf_cen_o, bus.rf_wen_o, bus.rf_addr_o, bus.rf_data_o} !== {m_cen, m_wen, m_addr, m_data}) begin
      n_err++;
      $display("FAIL %s pins cyc=%0d got cen=%b wen=%b addr=%h data=%h exp cen=%b wen=%b addr=%h data=%h",
               tag, cyc, bus.rf_cen_o, bus.rf_wen_o, bus.rf_addr_o, bus.rf_data_o, m_cen, m_wen, m_addr, m_data);
    end
  endtask

  // One clock cycle: check acks at negedge, update model, check registered outputs after posedge.
  task automatic tick();
    logic          wen;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    bit            ea, eb;
    logic [WW-1:0] ed;
    rd_t           keep[$];
    @(negedge clk);
    g_a = 0; g_b = 0;
    if (rst_n) begin
      if (bus.a_req_i && bus.b_req_i) begin
`ifdef RF_ARB_RR_EN
        if (m_last_b) g_a = 1; else g_b = 1;
`else
        g_a = 1;
`endif
      end else if (bus.a_req_i) g_a = 1;
      else if (bus.b_req_i) g_b = 1;
    end
    n_cmp++;
    if ({bus.a_ack_o, bus.b_ack_o} !== {g_a, g_b}) begin
      n_err++;
      $display("FAIL ack cyc=%0d got a=%b b=%b exp a=%b b=%b", cyc, bus.a_ack_o, bus.b_ack_o, g_a, g_b);
    end
    if (g_a || g_b) begin
      wen  = g_b ? bus.b_wen_i  : bus.a_wen_i;
      addr = g_b ? bus.b_addr_i : bus.a_addr_i;
      data = g_b ? bus.b_data_i : bus.a_data_i;
      m_cen = 0; m_wen = wen; m_addr = addr; m_data = data; m_last_b = g_b;
      if (!wen) m_mem[addr] = data;
      else      pend.push_back('{cyc + 2, g_b, m_mem[addr]});
      $display("cyc=%0d grant=%s %s addr=%h data=%h", cyc, g_b ? "B" : "A", wen ? "RD" : "WR", addr, wen ? m_mem[addr] : data);
    end else begin
      m_cen = 1; m_wen = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_pins("cycle");
    ea = 0; eb = 0; ed = '0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        if (pend[i].own) eb = 1; else ea = 1;
        ed = pend[i].d;
      end else if (pend[i].due > cyc) keep.push_back(pend[i]);
    end
    pend = keep;
    n_cmp++;
    if ({bus.a_rvalid_o, bus.b_rvalid_o} !== {ea, eb}) begin
      n_err++;
      $display("FAIL rvalid cyc=%0d got a=%b b=%b exp a=%b b=%b", cyc, bus.a_rvalid_o, bus.b_rvalid_o, ea, eb);
    end
    if (ea) begin
      n_cmp++;
      if (bus.a_rdata_o !== ed) begin
        n_err++;
        $display("FAIL a_rdata cyc=%0d got %h exp %h", cyc, bus.a_rdata_o, ed);
      end
    end
    if (eb) begin
      n_cmp++;
      if (bus.b_rdata_o !== ed) begin
        n_err++;
        $display("FAIL b_rdata cyc=%0d got %h exp %h", cyc, bus.b_rdata_o, ed);
      end
    end
  endtask

  // Asynchronous reset mid-run, held for n cycles, with immediate output checks.
  task automatic do_reset(int n);
    rst_n = 0;
    clear_reqs();
    bus.a_req_i = 1; bus.b_req_i = 1;
    #1;
    model_reset();
    check_pins("reset");
    n_cmp++;
    if ({bus.a_ack_o, bus.b_ack_o, bus.a_rvalid_o, bus.b_rvalid_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_out got ack=%b%b rvalid=%b%b exp 0000", bus.a_ack_o, bus.b_ack_o, bus.a_rvalid_o, bus.b_rvalid_o);
    end
    clear_reqs();
    repeat (n) tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    $display("test_reset");
    do_reset(2);
    repeat (5) tick();
  endtask

  task automatic test_write_read();
    $display("test_write_read");
    bus.a_req_i = 1; bus.a_wen_i = 0; bus.a_addr_i = 8'h10; bus.a_data_i = 32'hDEADBEEF;
    tick();
    bus.a_wen_i = 1;
    tick();
    clear_reqs();
    repeat (3) tick();
  endtask

  task automatic test_contention();
    $display("test_contention");
    do_reset(1);
    bus.a_req_i = 1; bus.a_wen_i = 1; bus.a_addr_i = 8'h01;
    bus.b_req_i = 1; bus.b_wen_i = 1; bus.b_addr_i = 8'h02;
    repeat (8) tick();
    bus.a_req_i = 0;
    tick();
    clear_reqs();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_read();
    $display("test_reset_mid_read");
    bus.b_req_i = 1; bus.b_wen_i = 1; bus.b_addr_i = 8'h20;
    tick();
    do_reset(2);
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    $display("test_back_to_back");
    bus.a_req_i = 1; bus.a_wen_i = 0; bus.a_addr_i = 8'h30; bus.a_data_i = 32'h00000055;
    tick();
    clear_reqs();
    bus.b_req_i = 1; bus.b_wen_i = 1; bus.b_addr_i = 8'h30;
    tick();
    clear_reqs();
    repeat (3) tick();
  endtask

  task automatic test_random();
    $display("test_random");
    g_a = 0; g_b = 0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.a_req_i || g_a) begin
        bus.a_req_i  = ($urandom_range(0, 3) != 0);
        bus.a_wen_i  = 1'($urandom_range(0, 1));
        bus.a_addr_i = AW'(8'h40 + $urandom_range(0, 7));
        bus.a_data_i = $urandom;
      end
      if (!bus.b_req_i || g_b) begin
        bus.b_req_i  = ($urandom_range(0, 3) != 0);
        bus.b_wen_i  = 1'($urandom_range(0, 1));
        bus.b_addr_i = AW'(8'h40 + $urandom_range(0, 7));
        bus.b_data_i = $urandom;
      end
      tick();
    end
    clear_reqs();
    repeat (3) tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i]   = init_val(i);
      m_mem[i] = init_val(i);
    end
    bus.rf_data_i = '0;
    clear_reqs();
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_contention();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
